// File: rtl/transposer_scheduler.sv
// Round-robin scheduler that shares one data_transposer between NUM_REQ input loaders.
// Each job is staged in full, then streamed gap-free while the MVU write port is steered.
module transposer_scheduler #(
    parameter int unsigned NUM_REQ       = 8,
    parameter int unsigned NUM_WORDS     = 64,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MVU_ADDR_LEN  = 32,
    parameter int unsigned MAX_DATA_PREC = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*32-1:0]           req_prec,
    input  logic [NUM_REQ*MVU_ADDR_LEN-1:0] req_baddr,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              wd_valid,
    input  logic [NUM_REQ*XLEN-1:0]         wd_data,
    output logic [NUM_REQ-1:0]              wd_ready,
    output logic [NUM_REQ-1:0]              done,
    output logic                            done_err,
    output logic                            tr_start,
    output logic [31:0]                     tr_prec,
    output logic [MVU_ADDR_LEN-1:0]         tr_baddr,
    output logic [XLEN-1:0]                 tr_iword,
    input  logic                            tr_busy,
    output logic [NUM_REQ-1:0]              mvu_sel
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(NUM_WORDS + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFill   = 3'd1;
    localparam logic [2:0] StLaunch = 3'd2;
    localparam logic [2:0] StStream = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [IDX_W-1:0]         rp_q, rp_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [31:0]              prec_q, prec_d;
    logic [MVU_ADDR_LEN-1:0]  baddr_q, baddr_d;
    logic [MAX_DATA_PREC-1:0] staging [NUM_WORDS];

    logic [31:0]              prec_lane  [NUM_REQ];
    logic [MVU_ADDR_LEN-1:0]  baddr_lane [NUM_REQ];
    logic [MAX_DATA_PREC-1:0] word_lane  [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            prec_lane[i]  = req_prec[i*32 +: 32];
            baddr_lane[i] = req_baddr[i*MVU_ADDR_LEN +: MVU_ADDR_LEN];
            word_lane[i]  = wd_data[i*XLEN +: MAX_DATA_PREC];
        end
    end

    // Only the low MAX_DATA_PREC bits of each word are staged.
    logic unused_wd_data;
    assign unused_wd_data = ^wd_data;

    // Round-robin search starting at rp_q, wrapping.
    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    int unsigned      scan;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = (32'(rp_q) + 32'(i)) % NUM_REQ;
            if (!gnt_found && req_valid[IDX_W'(scan)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(scan);
            end
        end
    end

    logic prec_ok;
    assign prec_ok = (prec_lane[gnt_idx] != 32'd0) &&
                     (prec_lane[gnt_idx] <= 32'(MAX_DATA_PREC));

    logic owner_wd_valid;
    assign owner_wd_valid = wd_valid[owner_q];

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        prec_d  = prec_q;
        baddr_d = baddr_q;
        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    prec_d  = prec_lane[gnt_idx];
                    baddr_d = baddr_lane[gnt_idx];
                    cnt_d   = '0;
                    err_d   = !prec_ok;
                    state_d = prec_ok ? StFill : StDone;
                end
            end
            StFill: begin
                if (owner_wd_valid) begin
                    if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = StLaunch;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLaunch: begin
                if (!tr_busy) begin
                    cnt_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                // The transposer samples NUM_WORDS+1 times; the last beat is a zero word.
                if (cnt_q == CNT_W'(NUM_WORDS)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (!tr_busy) state_d = StDone;
            end
            StDone: begin
                rp_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rp_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            prec_q  <= '0;
            baddr_q <= '0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            prec_q  <= prec_d;
            baddr_q <= baddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StFill && owner_wd_valid) begin
            staging[cnt_q[WIDX_W-1:0]] <= word_lane[owner_q];
        end
    end

    always_comb begin
        req_ready = '0;
        wd_ready  = '0;
        done      = '0;
        done_err  = 1'b0;
        tr_start  = 1'b0;
        tr_iword  = '0;
        mvu_sel   = '0;
        case (state_q)
            StIdle: begin
                if (gnt_found) req_ready = ONE << gnt_idx;
            end
            StFill: wd_ready = ONE << owner_q;
            StLaunch: begin
                if (!tr_busy) begin
                    tr_start = 1'b1;
                    mvu_sel  = ONE << owner_q;
                end
            end
            StStream: begin
                mvu_sel = ONE << owner_q;
                if (cnt_q < CNT_W'(NUM_WORDS)) begin
                    tr_iword = XLEN'(staging[cnt_q[WIDX_W-1:0]]);
                end
            end
            StDrain: mvu_sel = ONE << owner_q;
            StDone: begin
                done     = ONE << owner_q;
                done_err = err_q;
            end
            default: ;
        endcase
    end

    assign tr_prec  = prec_q;
    assign tr_baddr = baddr_q;

endmodule

// File: tb/tb_transposer_scheduler.sv
// Randomized bench for transposer_scheduler with a queue-based job model and a
// behavioural stand-in for the transposer's busy flag.
module tb_transposer_scheduler;
    localparam int NUM_REQ   = 8;
    localparam int NUM_WORDS = 64;
    localparam int XLEN      = 32;
    localparam int AW        = 32;
    localparam int MAXP      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*32-1:0]   req_prec;
    logic [NUM_REQ*AW-1:0]   req_baddr;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      wd_valid;
    logic [NUM_REQ*XLEN-1:0] wd_data;
    logic [NUM_REQ-1:0]      wd_ready;
    logic [NUM_REQ-1:0]      done;
    logic                    done_err;
    logic                    tr_start;
    logic [31:0]             tr_prec;
    logic [AW-1:0]           tr_baddr;
    logic [XLEN-1:0]         tr_iword;
    logic                    tr_busy;
    logic [NUM_REQ-1:0]      mvu_sel;

    logic [31:0]     prec_tab  [NUM_REQ];
    logic [AW-1:0]   baddr_tab [NUM_REQ];
    logic [XLEN-1:0] wd_tab    [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_prec[i*32 +: 32]     = prec_tab[i];
        assign req_baddr[i*AW +: AW]    = baddr_tab[i];
        assign wd_data[i*XLEN +: XLEN]  = wd_tab[i];
    end

    transposer_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .NUM_WORDS    (NUM_WORDS),
        .XLEN         (XLEN),
        .MVU_ADDR_LEN (AW),
        .MAX_DATA_PREC(MAXP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_prec (req_prec),
        .req_baddr(req_baddr),
        .req_ready(req_ready),
        .wd_valid (wd_valid),
        .wd_data  (wd_data),
        .wd_ready (wd_ready),
        .done     (done),
        .done_err (done_err),
        .tr_start (tr_start),
        .tr_prec  (tr_prec),
        .tr_baddr (tr_baddr),
        .tr_iword (tr_iword),
        .tr_busy  (tr_busy),
        .mvu_sel  (mvu_sel)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rp_m     = 0;
    int busy_cnt = 0;
    int busy_len = NUM_WORDS + 2;
    bit force_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] m, input int rp);
        int j;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (rp + i) % NUM_REQ;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    // One clock; the transposer model goes busy the cycle after it sees tr_start.
    task automatic tick();
        logic fire;
        #1;
        fire = tr_start;
        @(posedge clk);
        #1;
        if (rst) busy_cnt = 0;
        else if (fire) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        tr_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic run_job(input logic [NUM_REQ-1:0] mask, input int vmode, input int dmode,
                           input bit hold_busy, input int abort_at, input bit need_fast);
        int              g;
        int              waited;
        int              cyc;
        int              got;
        bit              v;
        bit              legal;
        bit              last_busy;
        bit              seen_done;
        logic [31:0]     exp_prec;
        logic [AW-1:0]   exp_baddr;
        logic [XLEN-1:0] w;
        logic [XLEN-1:0] exp_w;
        logic [MAXP-1:0] q [$];

        g = pick(mask, rp_m);
        if (g < 0) return;
        busy_len  = NUM_WORDS + 2 + int'($urandom_range(0, 6));
        req_valid = mask;
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 10) begin
            tick();
            waited++;
        end
        check("req_ready", req_ready, oh(g));
        if (need_fast) check("rr_next_grant_fast", waited <= 1, 1);
        if (req_ready == '0) return;

        exp_prec  = prec_tab[g];
        exp_baddr = baddr_tab[g];
        legal     = (exp_prec >= 1) && (exp_prec <= MAXP);
        tick();
        // Owner drops its request and rewrites its descriptor; latched values must hold.
        req_valid     = mask & ~oh(g);
        prec_tab[g]   = $urandom_range(1, MAXP);
        baddr_tab[g]  = $urandom;
        #1;
        check("tr_prec", tr_prec, exp_prec);
        check("tr_baddr", tr_baddr, exp_baddr);

        if (!legal) begin
            got = 0;
            for (int c = 1; c <= 3 && got == 0; c++) begin
                check("illegal_no_start", tr_start, 0);
                if (done != '0) got = c;
                else tick();
            end
            check("illegal_done_latency_ok", (got == 1) || (got == 2), 1);
            check("illegal_done", done, oh(g));
            check("illegal_done_err", done_err, 1);
            rp_m = (g + 1) % NUM_REQ;
            return;
        end

        q.delete();
        cyc = 0;
        while (q.size() < NUM_WORDS && cyc < 1000) begin
            for (int i = 0; i < NUM_REQ; i++) wd_tab[i] = $urandom;
            w = (dmode == 1) ? XLEN'(q.size()) : XLEN'($urandom);
            wd_tab[g] = w;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            wd_valid    = NUM_REQ'($urandom);
            wd_valid[g] = v;
            if (hold_busy && v && q.size() == NUM_WORDS - 1) force_busy = 1'b1;
            #1;
            check("wd_ready", wd_ready, oh(g));
            check("fill_no_start", tr_start, 0);
            if (v) q.push_back(w[MAXP-1:0]);
            tick();
            cyc++;
        end
        wd_valid = '0;
        #1;
        if (q.size() < NUM_WORDS) begin
            check("fill_timeout", q.size(), NUM_WORDS);
            return;
        end

        if (hold_busy) begin
            for (int c = 0; c < 4; c++) begin
                check("busy_hold_no_start", tr_start, 0);
                tick();
            end
            force_busy = 1'b0;
            tr_busy    = busy_cnt > 0;
            #1;
        end
        check("tr_start", tr_start, 1);
        check("launch_sel", mvu_sel, oh(g));
        tick();

        for (int k = 0; k <= NUM_WORDS; k++) begin
            if (k == abort_at) begin
                rst       = 1'b1;
                req_valid = '0;
                tick();
                rst = 1'b0;
                #1;
                check("abort_ctrl_zero", {req_ready, wd_ready, done, done_err, tr_start, mvu_sel}, 0);
                check("abort_word_zero", tr_iword, 0);
                check("abort_desc_zero", {tr_prec, tr_baddr}, 0);
                seen_done = 1'b0;
                for (int c = 0; c < 150; c++) begin
                    seen_done |= (done != '0);
                    tick();
                end
                check("abort_no_done", seen_done, 0);
                rp_m = 0;
                return;
            end
            exp_w = '0;
            if (k < NUM_WORDS) exp_w[MAXP-1:0] = q[k];
            check("stream_word", tr_iword, exp_w);
            check("stream_sel", mvu_sel, oh(g));
            check("stream_no_start", tr_start, 0);
            tick();
        end

        got       = 0;
        last_busy = 1'b1;
        for (int c = 0; c < 300 && got == 0; c++) begin
            if (done != '0) begin
                got = 1;
                check("done_after_busy_low", last_busy, 0);
            end else begin
                check("done_on_time", 1'b0, !last_busy);
                check("drain_sel", mvu_sel, oh(g));
                last_busy = tr_busy;
                tick();
            end
        end
        check("done_seen", got, 1);
        check("done", done, oh(g));
        check("done_err", done_err, 0);
        check("done_sel_clear", mvu_sel, 0);
        rp_m = (g + 1) % NUM_REQ;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            prec_tab[i]  = $urandom_range(1, MAXP);
            baddr_tab[i] = $urandom;
            wd_tab[i]    = '0;
        end
        req_valid = '0;
        wd_valid  = '0;
        tr_busy   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        check("reset_ctrl_zero", {req_ready, wd_ready, done, done_err, tr_start, mvu_sel}, 0);
        check("reset_data_zero", {tr_prec, tr_baddr}, 0);
        check("reset_word_zero", tr_iword, 0);
        rst = 1'b0;
        tick();

        // All requesters active: grants rotate 0..7 then wrap to 0.
        for (int n = 0; n < NUM_REQ + 1; n++) run_job('1, 2, 0, 1'b0, -1, n > 0);

        prec_tab[0]  = 4;
        baddr_tab[0] = 32'h100;
        run_job(8'h01, 0, 1, 1'b0, -1, 1'b0);

        run_job(8'h08, 1, 0, 1'b0, -1, 1'b0);

        prec_tab[2] = 0;
        run_job(8'h04, 0, 0, 1'b0, -1, 1'b0);
        prec_tab[2] = 9;
        run_job(8'h04, 0, 0, 1'b0, -1, 1'b0);

        run_job(8'h40, 2, 0, 1'b1, -1, 1'b0);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NUM_REQ; i++) prec_tab[i] = $urandom_range(0, MAXP + 2);
            run_job(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 2, 0, 1'b0, -1, 1'b0);
        end

        for (int i = 0; i < NUM_REQ; i++) prec_tab[i] = $urandom_range(1, MAXP);
        run_job(8'h20, 0, 0, 1'b0, 20, 1'b0);
        run_job(8'h81, 2, 0, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1);
    end

endmodule
